pulse_req_tx: RTL and testbench

PULSE_REQ_TX -- requirements
Module: pulse_req_tx

---
 rtl/pulse_req_tx_pkg.sv | 15 +
 rtl/cdc_sync_bit.sv | 24 ++
 rtl/pulse_req_tx.sv | 101 ++++++++++
 tb/tb_pulse_req_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_req_tx_pkg.sv
// Shared CDC definitions for the four-phase pulse request transmitter and its
// receive-side counterpart.
package pulse_req_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ_HI = 2'b01,
    ST_REQ_LO = 2'b10
  } req_state_e;

  function automatic logic req_level(input req_state_e st);
    return (st == ST_REQ_HI);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pulse_req_tx.sv
// Converts single-cycle pulses into queued four-phase req/ack handshakes
// towards an asynchronous destination domain.
module pulse_req_tx
  import pulse_req_tx_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam int               SETTLE_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  req_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]    pend_r, pend_nxt_s;
  logic [SETTLE_W-1:0] settle_r;
  logic                req_r, busy_r, ovf_r;
  logic                ack_s, launch_s, inc_s, dec_s, drop_s;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_s)
  );

  // Launch/queue decisions; launches wait for the synchronizer to refill after
  // reset so a stale-high ack from an interrupted handshake is never missed
  always_comb begin
    launch_s = (state_r == ST_IDLE) && (settle_r == SETTLE_DONE) && !ack_s &&
               (pulse_in || (pend_r != '0));
    dec_s    = launch_s && (pend_r != '0);
    inc_s    = pulse_in && !(launch_s && (pend_r == '0));
    drop_s   = inc_s && !dec_s && (pend_r == CNT_MAX);
    if (inc_s && !dec_s && !drop_s) begin
      pend_nxt_s = pend_r + CNT_W'(1);
    end else if (dec_s && !inc_s) begin
      pend_nxt_s = pend_r - CNT_W'(1);
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Handshake next-state logic; unexpected ack levels leave the state alone
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) state_nxt_s = ST_REQ_HI;
        else          state_nxt_s = ST_IDLE;
      end
      ST_REQ_HI: begin
        if (ack_s) state_nxt_s = ST_REQ_LO;
        else       state_nxt_s = ST_REQ_HI;
      end
      ST_REQ_LO: begin
        if (!ack_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_REQ_LO;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, queue, flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pend_r   <= '0;
      settle_r <= '0;
      req_r    <= 1'b0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      req_r   <= req_level(state_nxt_s);
      busy_r  <= (state_nxt_s != ST_IDLE) || (pend_nxt_s != '0);
      if (settle_r != SETTLE_DONE) settle_r <= settle_r + SETTLE_W'(1);
      else                         settle_r <= settle_r;
      if (drop_s)       ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
      else              ovf_r <= ovf_r;
    end
  end

  assign req_out  = req_r;
  assign busy     = busy_r;
  assign pend_cnt = pend_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_pulse_req_tx.sv
// Directed self-checking bench for pulse_req_tx: latency, queueing, overflow,
// reset mid-handshake and a randomized-ack protocol run.
`timescale 1ns/1ps
module tb_pulse_req_tx;

  logic clk = 1'b0, ack_clk = 1'b0, rst_n = 1'b0;
  logic pulse_in = 1'b0, ovf_clr = 1'b0, ack_man = 1'b0, ack_auto = 1'b0, ack_rnd = 1'b0;
  logic ack_resp = 1'b0;
  logic ack_in;
  logic req_out, busy, ovf;
  logic [3:0] pend_cnt;
  logic pulse2 = 1'b0, ovf_clr2 = 1'b0, ack2 = 1'b0;
  logic req2, busy2, ovf2;
  logic [1:0] pend2;
  int base_dly = 3, rnd_dly = 0, resp_cnt = 0;
  int checks = 0, errors = 0, hs_cnt = 0, viol = 0;
  logic m1, m2, ack_s_prev, req_prev;

  assign ack_in = ack_auto ? ack_resp : ack_man;

  pulse_req_tx #(.CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .ack_in(ack_in),
    .req_out(req_out), .busy(busy), .pend_cnt(pend_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  pulse_req_tx #(.CNT_W(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse2), .ack_in(ack2),
    .req_out(req2), .busy(busy2), .pend_cnt(pend2), .ovf(ovf2), .ovf_clr(ovf_clr2)
  );

  // clk rises on odd ns, ack_clk on even ns: unrelated domains, no edge races
  always #5 clk = ~clk;
  initial begin
    #2;
    forever #4 ack_clk = ~ack_clk;
  end

  // Destination-side responder: mirrors req_out after a delay in ack_clk cycles
  always @(posedge ack_clk) begin
    if (!ack_auto) begin
      ack_resp <= 1'b0;
      resp_cnt <= 0;
    end else if (ack_resp != req_out) begin
      if (resp_cnt >= (ack_rnd ? rnd_dly : base_dly)) begin
        ack_resp <= req_out;
        resp_cnt <= 0;
        rnd_dly  <= $urandom_range(0, 20);
      end else begin
        resp_cnt <= resp_cnt + 1;
      end
    end else begin
      resp_cnt <= 0;
    end
  end

  // Reference two-stage view of ack_in, as the source domain sees it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= 1'b0; m2 <= 1'b0; ack_s_prev <= 1'b0;
    end else begin
      m1 <= ack_in; m2 <= m1; ack_s_prev <= m2;
    end
  end

  // Protocol monitor: req_out must not rise while synchronized ack is high
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev <= 1'b0;
    end else begin
      if (req_out && !req_prev && ack_s_prev) begin
        viol <= viol + 1;
        $display("protocol violation: req_out rose with ack_s=1 at %0t", $time);
      end
      if (!req_out && req_prev) hs_cnt <= hs_cnt + 1;
      req_prev <= req_out;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL reset_pend: got %0d want 0", pend_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (pend2 !== 2'd0 || req2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: got pend=%0d req=%b want 0/0", pend2, req2); end
  endtask

  task automatic test_single;
    int h0;
    ack_auto = 1'b1; base_dly = 3;
    h0 = hs_cnt;
    pulse_in = 1'b1; tick; pulse_in = 1'b0;
    checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL single_latency: req=%b want 1", req_out); end
    checks++; if (pend_cnt !== 4'd0) begin errors++; $display("FAIL single_pend: got %0d want 0", pend_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 100 && m2 !== 1'b1; i++) tick;
    checks++; if (req_out !== 1'b1 || m2 !== 1'b1) begin errors++; $display("FAIL single_ack_seen: req=%b ack_s=%b want 1/1", req_out, m2); end
    tick;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL single_fall: req=%b want 0", req_out); end
    for (int i = 0; i < 200 && busy; i++) tick;
    repeat (2) tick;
    checks++; if (busy !== 1'b0 || pend_cnt !== 4'd0) begin errors++; $display("FAIL single_idle: busy=%b pend=%0d want 0/0", busy, pend_cnt); end
    checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL single_hs: got %0d want 1", hs_cnt - h0); end
  endtask

  task automatic test_burst;
    int h0, exp_v;
    logic [3:0] last;
    ack_auto = 1'b1; base_dly = 6;
    h0 = hs_cnt;
    pulse_in = 1'b1; repeat (6) tick; pulse_in = 1'b0;
    checks++; if (pend_cnt !== 4'd5) begin errors++; $display("FAIL burst_peak: got %0d want 5", pend_cnt); end
    exp_v = 4; last = pend_cnt;
    for (int i = 0; i < 3000 && busy; i++) begin
      tick;
      if (pend_cnt !== last) begin
        checks++; if (pend_cnt !== 4'(exp_v)) begin errors++; $display("FAIL burst_step: got %0d want %0d", pend_cnt, exp_v); end
        exp_v--; last = pend_cnt;
      end
    end
    repeat (2) tick;
    checks++; if (exp_v !== -1) begin errors++; $display("FAIL burst_steps_seen: remaining %0d want -1", exp_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy: got %b want 0", busy); end
    checks++; if (hs_cnt - h0 !== 6) begin errors++; $display("FAIL burst_hs: got %0d want 6", hs_cnt - h0); end
  endtask

  task automatic test_simul_dequeue;
    int h0;
    ack_auto = 1'b0; ack_man = 1'b0; base_dly = 3;
    h0 = hs_cnt;
    pulse_in = 1'b1; repeat (3) tick; pulse_in = 1'b0;
    checks++; if (pend_cnt !== 4'd2 || req_out !== 1'b1) begin errors++; $display("FAIL simul_setup: pend=%0d req=%b want 2/1", pend_cnt, req_out); end
    ack_man = 1'b1;
    for (int i = 0; i < 50 && req_out; i++) tick;
    ack_man = 1'b0;
    for (int i = 0; i < 50 && m2 !== 1'b0; i++) tick;
    tick;
    pulse_in = 1'b1; tick; pulse_in = 1'b0;
    checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL simul_launch: req=%b want 1", req_out); end
    checks++; if (pend_cnt !== 4'd2) begin errors++; $display("FAIL simul_pend: got %0d want 2", pend_cnt); end
    ack_auto = 1'b1;
    for (int i = 0; i < 3000 && busy; i++) tick;
    repeat (2) tick;
    checks++; if (hs_cnt - h0 !== 4 || pend_cnt !== 4'd0) begin errors++; $display("FAIL simul_drain: hs=%0d pend=%0d want 4/0", hs_cnt - h0, pend_cnt); end
  endtask

  task automatic test_overflow;
    int n;
    ack2 = 1'b0;
    pulse2 = 1'b1; repeat (4) tick;
    checks++; if (pend2 !== 2'd3 || ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_full: pend=%0d ovf=%b want 3/0", pend2, ovf2); end
    tick; pulse2 = 1'b0;
    checks++; if (pend2 !== 2'd3 || ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_drop: pend=%0d ovf=%b want 3/1", pend2, ovf2); end
    pulse2 = 1'b1; ovf_clr2 = 1'b1; tick; pulse2 = 1'b0; ovf_clr2 = 1'b0;
    checks++; if (ovf2 !== 1'b1 || pend2 !== 2'd3) begin errors++; $display("FAIL ovf_set_wins: ovf=%b pend=%0d want 1/3", ovf2, pend2); end
    ovf_clr2 = 1'b1; tick; ovf_clr2 = 1'b0;
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf2); end
    n = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 50 && !req2; i++) tick;
      if (!req2) break;
      n++;
      ack2 = 1'b1;
      for (int i = 0; i < 50 && req2; i++) tick;
      ack2 = 1'b0;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL ovf_hs: got %0d want 4", n); end
    checks++; if (pend2 !== 2'd0 || busy2 !== 1'b0) begin errors++; $display("FAIL ovf_idle: pend=%0d busy=%b want 0/0", pend2, busy2); end
  endtask

  task automatic test_reset_mid;
    logic rose;
    ack_auto = 1'b0; ack_man = 1'b0;
    pulse_in = 1'b1; repeat (4) tick; pulse_in = 1'b0;
    checks++; if (pend_cnt !== 4'd3 || req_out !== 1'b1) begin errors++; $display("FAIL rstmid_setup: pend=%0d req=%b want 3/1", pend_cnt, req_out); end
    ack_man = 1'b1; tick;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_out !== 1'b0 || pend_cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: req=%b pend=%0d busy=%b want 0/0/0", req_out, pend_cnt, busy); end
    repeat (2) tick;
    rst_n = 1'b1;
    pulse_in = 1'b1; tick; pulse_in = 1'b0;
    rose = 1'b0;
    repeat (12) begin tick; if (req_out) rose = 1'b1; end
    checks++; if (rose !== 1'b0) begin errors++; $display("FAIL rstmid_hold: req rose=%b want 0", rose); end
    checks++; if (pend_cnt !== 4'd1) begin errors++; $display("FAIL rstmid_queued: got %0d want 1", pend_cnt); end
    ack_man = 1'b0;
    for (int i = 0; i < 20 && !req_out; i++) tick;
    checks++; if (req_out !== 1'b1 || pend_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_launch: req=%b pend=%0d want 1/0", req_out, pend_cnt); end
    ack_auto = 1'b1;
    for (int i = 0; i < 300 && busy; i++) tick;
    repeat (2) tick;
  endtask

  task automatic test_random_protocol;
    int h0;
    ack_auto = 1'b1; ack_rnd = 1'b1;
    h0 = hs_cnt;
    for (int p = 0; p < 12; p++) begin
      pulse_in = 1'b1; tick; pulse_in = 1'b0;
      repeat ($urandom_range(0, 15)) tick;
    end
    for (int i = 0; i < 8000 && busy; i++) tick;
    repeat (3) tick;
    ack_rnd = 1'b0;
    checks++; if (hs_cnt - h0 !== 12) begin errors++; $display("FAIL rand_hs: got %0d want 12", hs_cnt - h0); end
    checks++; if (ovf !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_flags: ovf=%b busy=%b want 0/0", ovf, busy); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL protocol_rise_with_ack: got %0d violations want 0", viol); end
  endtask

  initial begin
    repeat (3) tick;
    test_reset;
    rst_n = 1'b1;
    repeat (6) tick;
    test_single;
    test_burst;
    test_simul_dequeue;
    test_overflow;
    test_reset_mid;
    test_random_protocol;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
